// File: rtl/dmem_mmio_pkg.sv
// Shared definitions for the data-memory / MMIO subsystem: address map,
// UART status bit positions and the transmitter state encoding.
package dmem_mmio_pkg;

   localparam logic [11:0] DMEM_BASE      = 12'h800;
   localparam logic [11:0] LED_ADDR       = 12'hC00;
   localparam logic [11:0] DIP_ADDR       = 12'hC04;
   localparam logic [11:0] UART_DATA_ADDR = 12'hC08;
   localparam logic [11:0] UART_STAT_ADDR = 12'hC0C;

   localparam int STAT_FULL_BIT  = 0;
   localparam int STAT_EMPTY_BIT = 1;
   localparam int STAT_BUSY_BIT  = 2;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

   // Word address hits a single MMIO register only when the upper bits are zero
   function automatic logic reg_hit(input logic [29:0] word_addr, input logic [11:0] reg_addr);
      return {word_addr, 2'b00} == {20'd0, reg_addr[11:2], 2'b00};
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: circular byte FIFO feeding a bit-timing FSM.
// The serial line is registered so it never glitches.
module uart_tx_fifo
   import dmem_mmio_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int BAUD_DIV   = 868
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [7:0] data,
   output logic       full,
   output logic       empty,
   output logic       busy,
   output logic       tx
);

   localparam int IW = $clog2(FIFO_DEPTH);
   localparam int PW = IW + 1;
   localparam int BW = $clog2(BAUD_DIV);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

   logic [7:0]    fifo_mem_r [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   tx_state_e     state_r;
   tx_state_e     state_next_s;
   logic [BW-1:0] baud_r;
   logic [2:0]    bit_idx_r;
   logic [7:0]    shift_r;
   logic          tx_r;
   logic          empty_s;
   logic          full_s;
   logic          push_ok_s;
   logic          pop_s;
   logic          baud_wrap_s;
   logic          tx_next_s;

   assign empty_s     = (wr_ptr_r == rd_ptr_r);
   assign full_s      = (wr_ptr_r[PW-1] != rd_ptr_r[PW-1]) &&
                        (wr_ptr_r[IW-1:0] == rd_ptr_r[IW-1:0]);
   // A push into a full FIFO is lost even if the FSM pops in the same cycle
   assign push_ok_s   = push && !full_s;
   assign baud_wrap_s = (baud_r == BAUD_LAST);

   // FIFO storage; only entries between the pointers are ever read
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         fifo_mem_r[wr_ptr_r[IW-1:0]] <= data;
      end
   end

   // FIFO pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1'b1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1'b1);
         end
      end
   end

   // TX FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= TX_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // TX FSM next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         TX_IDLE: begin
            if (!empty_s) state_next_s = TX_START;
            else          state_next_s = TX_IDLE;
         end
         TX_START: begin
            if (baud_wrap_s) state_next_s = TX_DATA;
            else             state_next_s = TX_START;
         end
         TX_DATA: begin
            if (baud_wrap_s && (bit_idx_r == 3'd7)) state_next_s = TX_STOP;
            else                                    state_next_s = TX_DATA;
         end
         TX_STOP: begin
            if (baud_wrap_s) state_next_s = TX_IDLE;
            else             state_next_s = TX_STOP;
         end
         default: state_next_s = TX_IDLE;
      endcase
   end

   // TX FSM outputs: head pop and next serial level
   always_comb begin
      pop_s     = 1'b0;
      tx_next_s = 1'b1;
      case (state_r)
         TX_IDLE: begin
            pop_s     = !empty_s;
            tx_next_s = 1'b1;
         end
         TX_START: tx_next_s = 1'b0;
         TX_DATA:  tx_next_s = shift_r[0];
         TX_STOP:  tx_next_s = 1'b1;
         default:  tx_next_s = 1'b1;
      endcase
   end

   // Bit timing, shift register and registered serial line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         baud_r    <= '0;
         bit_idx_r <= 3'd0;
         shift_r   <= 8'd0;
         tx_r      <= 1'b1;
      end else begin
         tx_r <= tx_next_s;
         if ((state_r == TX_IDLE) || baud_wrap_s) begin
            baud_r <= '0;
         end else begin
            baud_r <= baud_r + BW'(1'b1);
         end
         if (pop_s) begin
            shift_r <= fifo_mem_r[rd_ptr_r[IW-1:0]];
         end else if ((state_r == TX_DATA) && baud_wrap_s) begin
            shift_r <= {1'b0, shift_r[7:1]};
         end
         if (state_r == TX_START) begin
            bit_idx_r <= 3'd0;
         end else if ((state_r == TX_DATA) && baud_wrap_s) begin
            bit_idx_r <= bit_idx_r + 3'd1;
         end
      end
   end

   assign full  = full_s;
   assign empty = empty_s;
   assign busy  = (state_r != TX_IDLE);
   assign tx    = tx_r;

endmodule

// File: rtl/data_mem_mmio.sv
// Data-side memory for the core's Memory stage: word RAM plus LED, DIP and
// UART registers. ReadData is combinational so Writeback can capture it.
module data_mem_mmio
   import dmem_mmio_pkg::*;
#(
   parameter int DMEM_WORDS = 128,
   parameter int FIFO_DEPTH = 8,
   parameter int BAUD_DIV   = 868,
   parameter int LED_WIDTH  = 8,
   parameter int DIP_WIDTH  = 16
) (
   input  logic                 CLK,
   input  logic                 Reset_n,
   input  logic                 MemWrite,
   input  logic [31:0]          Addr,
   input  logic [31:0]          WriteData,
   output logic [31:0]          ReadData,
   input  logic [DIP_WIDTH-1:0] DIP,
   output logic [LED_WIDTH-1:0] LED,
   output logic                 UART_TX
);

   localparam int AW = $clog2(DMEM_WORDS);
   localparam logic [11:0] DMEM_LAST = DMEM_BASE + 12'(DMEM_WORDS * 4 - 1);

   logic [31:0]          dmem_r [DMEM_WORDS];
   logic [LED_WIDTH-1:0] led_r;
   logic [DIP_WIDTH-1:0] dip_meta_r;
   logic [DIP_WIDTH-1:0] dip_sync_r;
   logic                 dmem_hit_s;
   logic                 led_hit_s;
   logic                 dip_hit_s;
   logic                 udata_hit_s;
   logic                 ustat_hit_s;
   logic [AW-1:0]        dmem_idx_s;
   logic                 fifo_full_s;
   logic                 fifo_empty_s;
   logic                 tx_busy_s;
   logic [31:0]          stat_s;
   logic [31:0]          read_s;
   logic                 unused_addr_s;

   assign unused_addr_s = ^Addr[1:0];

   // RAM base is aligned to the RAM size, so the index is plain address bits
   assign dmem_hit_s  = (Addr[31:12] == 20'd0) &&
                        (Addr[11:0] >= DMEM_BASE) && (Addr[11:0] <= DMEM_LAST);
   assign dmem_idx_s  = Addr[AW+1:2];
   assign led_hit_s   = reg_hit(Addr[31:2], LED_ADDR);
   assign dip_hit_s   = reg_hit(Addr[31:2], DIP_ADDR);
   assign udata_hit_s = reg_hit(Addr[31:2], UART_DATA_ADDR);
   assign ustat_hit_s = reg_hit(Addr[31:2], UART_STAT_ADDR);

   // Data RAM write port; contents deliberately survive reset
   always_ff @(posedge CLK) begin
      if (MemWrite && dmem_hit_s) begin
         dmem_r[dmem_idx_s] <= WriteData;
      end
   end

   // LED register and two-flop DIP synchroniser
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         led_r      <= '0;
         dip_meta_r <= '0;
         dip_sync_r <= '0;
      end else begin
         if (MemWrite && led_hit_s) begin
            led_r <= WriteData[LED_WIDTH-1:0];
         end
         dip_meta_r <= DIP;
         dip_sync_r <= dip_meta_r;
      end
   end

   uart_tx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .BAUD_DIV   (BAUD_DIV)
   ) u_uart (
      .clk   (CLK),
      .rst_n (Reset_n),
      .push  (MemWrite && udata_hit_s),
      .data  (WriteData[7:0]),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .busy  (tx_busy_s),
      .tx    (UART_TX)
   );

   // UART status word
   always_comb begin
      stat_s                 = 32'd0;
      stat_s[STAT_FULL_BIT]  = fifo_full_s;
      stat_s[STAT_EMPTY_BIT] = fifo_empty_s;
      stat_s[STAT_BUSY_BIT]  = tx_busy_s;
   end

   // Load data mux; UART_DATA and unmapped addresses read as zero
   always_comb begin
      read_s = 32'd0;
      if (dmem_hit_s) begin
         read_s = dmem_r[dmem_idx_s];
      end else if (led_hit_s) begin
         read_s = 32'(led_r);
      end else if (dip_hit_s) begin
         read_s = 32'(dip_sync_r);
      end else if (ustat_hit_s) begin
         read_s = stat_s;
      end else begin
         read_s = 32'd0;
      end
   end

   assign ReadData = read_s;
   assign LED      = led_r;

endmodule

// File: doc/data_mem_mmio.md
Name: data_mem_mmio

Overview:
Data-side memory subsystem consumed by the pipelined core's Memory stage.
- Inputs: the core's MemWrite, ALUResult (as Addr) and WriteData.
- Output: ReadData, returned combinationally in the same cycle, because the core registers it into Writeback at the next edge.
- Contents: word-addressed data RAM plus memory-mapped I/O (LED register, synchronised DIP switches, and a buffered UART transmitter with its own FIFO and bit-timing FSM).

Parameters:
- DMEM_WORDS, 128, data RAM depth in 32-bit words (power of 2).
- FIFO_DEPTH, 8, UART TX FIFO entries (power of 2, ≥2).
- BAUD_DIV, 868, clock cycles per UART bit (100 MHz / 115200); minimum 2.
- LED_WIDTH, 8, width of LED output register.
- DIP_WIDTH, 16, width of DIP switch input.

Ports:
- CLK  input  1  system clock, all state on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- MemWrite  input  1  write strobe from core Memory stage.
- Addr  input  32  byte address (core ALUResult); bits [1:0] ignored.
- WriteData  input  32  store data.
- ReadData  output  32  load data, combinational from Addr.
- DIP  input  DIP_WIDTH  asynchronous switch inputs.
- LED  output  LED_WIDTH  LED register.
- UART_TX  output  1  serial line, idle high, 8N1.

Behaviour:
- Address map (word-aligned):
  - DMEM 0x800 .. 0x800+4*DMEM_WORDS-1, read/write.
  - LED 0xC00, read/write, low LED_WIDTH bits.
  - DIP 0xC04, read only.
  - UART_DATA 0xC08, write only; reads return 0.
  - UART_STAT 0xC0C, read only.
  - Any other address: read returns 0, write ignored. Addr[31:12] must be 0 to hit any region.
- ReadData is purely combinational on Addr, with no read-enable. Unused upper bits are zero-extended.
- DMEM: synchronous write on CLK when MemWrite and hit. Reads are asynchronous. Reset does not clear contents; simulation initial value is 0.
- LED: written on CLK when MemWrite and hit; takes WriteData[LED_WIDTH-1:0]. Reset value 0.
- DIP: two-flop synchroniser, reset value 0. A read reflects a pin change 2 clock edges later.
- UART_STAT bits:
  - bit0 = fifo_full.
  - bit1 = fifo_empty.
  - bit2 = tx_busy (FSM not IDLE).
  - Others 0.
  - Reset value 0x2.
- FIFO:
  - Circular buffer with log2(FIFO_DEPTH)+1-bit pointers; full/empty derived from pointers.
  - Push on MemWrite to UART_DATA when not full; data is WriteData[7:0]. A write when full is dropped silently, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: both take effect and the count is unchanged.
- TX FSM states:
  - IDLE: UART_TX=1. If FIFO not empty, pop the head into the shift register, clear the baud counter, go to START. The pop occurs in the same cycle as the transition.
  - START: UART_TX=0 for BAUD_DIV cycles, then DATA with bit index 0.
  - DATA: UART_TX = shift[0], LSB first, BAUD_DIV cycles per bit. After bit 7 go to STOP.
  - STOP: UART_TX=1 for BAUD_DIV cycles, then IDLE. If the FIFO is non-empty, the next START begins on the cycle after re-entering IDLE, giving 1 extra idle cycle between frames.
- Baud counter counts 0..BAUD_DIV-1 and wraps. A state or bit advances on the wrap.
- Frame length is 10*BAUD_DIV cycles, measured from the START entry edge.
- UART_TX is driven from a register: no glitches, one-cycle registered latency from state.
- Reset (Reset_n low, any time including mid-frame):
  - UART_TX=1 immediately.
  - FSM to IDLE; FIFO emptied (pointers 0); baud counter 0.
  - LED=0; DIP synchroniser 0.
  - DMEM retained.

Decomposition:
- Shared package dmem_mmio_pkg:
  - Address constants DMEM_BASE, LED_ADDR, DIP_ADDR, UART_DATA_ADDR, UART_STAT_ADDR.
  - STAT bit indices.
  - TX FSM state encoding (IDLE, START, DATA, STOP; 2-bit).
- Sub-module uart_tx_fifo (FIFO + TX FSM, push/data/full/empty/busy/tx ports). The top level holds decode, DMEM, LED and the DIP synchroniser.

Test Plan (bench uses BAUD_DIV=4, FIFO_DEPTH=8):
- Reset check: hold Reset_n low, then release → LED=0, UART_TX=1, read 0xC0C → 0x2, read 0x9FC unmapped? No: read 0xA00 → 0.
- DMEM: write 0xDEADBEEF to 0x804, then read 0x804 → 0xDEADBEEF in the same cycle as Addr is applied. Write to 0x1804 → no effect; read 0x804 unchanged.
- LED and DIP:
  - Write 0x1A5 to 0xC00 → LED=0xA5.
  - Set DIP=0x1234 → read 0xC04 is 0 for 1 edge, then 0x1234 after the 2nd edge.
- Single frame: write 0x55 to 0xC08 → UART_TX bits 0,1,0,1,0,1,0,1,0,1, each 4 cycles (40 cycles total). STAT bit2=1 during the frame; STAT=0x2 after.
- Overflow: write 10 bytes 0x00..0x09 back-to-back while idle → the first byte is popped at once, so 8 are buffered and full is asserted after the 9th write. The 10th write is dropped. Serial output is bytes 0x00..0x08, 41 cycles apart.
- Reset mid-frame: assert Reset_n low during DATA bit 3 of a queued transfer → UART_TX=1 asynchronously, STAT=0x2 after release, no further frames, DMEM data at 0x804 retained.
